testfmem_ws: RTL and testbench



---
 rtl/testfmem_pkg.sv | 17 +
 rtl/testfmem_ws_if.sv | 33 +++
 rtl/testfmem_wait_ctr.sv | 40 ++++
 rtl/testfmem_ws.sv | 101 ++++++++++
 tb/tb_testfmem_ws.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/testfmem_pkg.sv
// Shared constants and types for the testfmem family of bus test slaves.
package testfmem_pkg;

  // PDP-6 word and bus address widths
  localparam int unsigned Pdp6DataW = 36;
  localparam int unsigned Pdp6AddrW = 18;

  // Width of the access wait counter (WAIT_CYCLES range 0..15)
  localparam int unsigned CntW = 4;

  // Power-up clear sequencer state
  typedef enum logic {
    StClear = 1'b0,
    StRun   = 1'b1
  } clear_state_e;

endpackage

// File: rtl/testfmem_ws_if.sv
// Avalon-MM-style word bus between a master and a testfmem slave.
// Signal names keep the slave-side view (i_ = into slave, o_ = out of slave).
interface testfmem_ws_if import testfmem_pkg::*; #(
  parameter int unsigned DATA_W = Pdp6DataW,
  parameter int unsigned ADDR_W = Pdp6AddrW
);

  logic [ADDR_W-1:0] i_address;
  logic              i_write;
  logic              i_read;
  logic [DATA_W-1:0] i_writedata;
  logic [DATA_W-1:0] o_readdata;
  logic              o_waitrequest;

  modport master (
    output i_address,
    output i_write,
    output i_read,
    output i_writedata,
    input  o_readdata,
    input  o_waitrequest
  );

  modport slave (
    input  i_address,
    input  i_write,
    input  i_read,
    input  i_writedata,
    output o_readdata,
    output o_waitrequest
  );

endinterface

// File: rtl/testfmem_wait_ctr.sv
// Access wait-state counter: stalls each request for WAIT_CYCLES cycles, then
// accepts it. Dropping the request mid-wait aborts and restarts the count.
// i_hold forces a stall with the counter parked at zero (used while clearing).
module testfmem_wait_ctr import testfmem_pkg::*; #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_req,
  input  logic i_hold,
  output logic o_waitrequest,
  output logic o_accept
);

  localparam logic [CntW-1:0] WaitCnt = CntW'(WAIT_CYCLES);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  assign o_waitrequest = i_hold | (i_req & (cnt_q != WaitCnt));
  assign o_accept      = i_req & ~o_waitrequest;

  // Count stall edges; accept, idle and hold all return the counter to zero
  always_comb begin
    cnt_d = '0;
    if (i_req && !i_hold && o_waitrequest) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Wait counter register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/testfmem_ws.sv
// Word-addressed test memory slave with configurable wait states.
// Upper address bits above DEPTH_LOG2 are ignored, so the array aliases.
// Optional macro TESTFMEM_CLEAR_EN: zero the whole array after every reset,
// stalling the bus until the sweep is done.
module testfmem_ws import testfmem_pkg::*; #(
  parameter int unsigned DATA_W      = Pdp6DataW,
  parameter int unsigned ADDR_W      = Pdp6AddrW,
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  testfmem_ws_if.slave  bus
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  logic [DATA_W-1:0]     mem [Depth];
  logic [DEPTH_LOG2-1:0] addr;
  logic                  unused_addr_hi;
  logic                  req;
  logic                  waitreq;
  logic                  accept;
  logic                  clearing;
  logic [DEPTH_LOG2-1:0] clr_idx;
  logic                  bus_we;

  assign addr           = bus.i_address[DEPTH_LOG2-1:0];
  assign unused_addr_hi = ^bus.i_address[ADDR_W-1:DEPTH_LOG2];
  assign req            = bus.i_read | bus.i_write;

`ifdef TESTFMEM_CLEAR_EN
  clear_state_e          state_q;
  clear_state_e          state_d;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [DEPTH_LOG2-1:0] idx_d;

  // Clear sweep: one word per cycle, then hand the bus over
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == StClear) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == '1) begin
        state_d = StRun;
      end
    end
  end

  // Clear sequencer state and sweep index
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StClear;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign clearing = (state_q == StClear);
  assign clr_idx  = idx_q;
`else
  assign clearing = 1'b0;
  assign clr_idx  = '0;
`endif

  testfmem_wait_ctr #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_ctr (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_req         (req),
    .i_hold        (clearing),
    .o_waitrequest (waitreq),
    .o_accept      (accept)
  );

  // Reset gates bus writes: with zero wait states accept is otherwise live in reset
  assign bus_we = accept & bus.i_write & i_reset_n;

  // Storage array; not reset, cleared by the optional sweep instead
  always_ff @(posedge i_clk) begin
    if (clearing) begin
      mem[clr_idx] <= '0;
    end else if (bus_we) begin
      mem[addr] <= bus.i_writedata;
    end
  end

  // Combinational read port; shows the pre-write word on a read+write accept
  always_comb begin
    bus.o_readdata = '0;
    if (bus.i_read && !waitreq) begin
      bus.o_readdata = mem[addr];
    end
  end

  assign bus.o_waitrequest = waitreq;

endmodule

// File: tb/tb_testfmem_ws.sv
// Self-checking bench for testfmem_ws: one slave with 2 wait states and one
// with none, both checked against a word-array reference model.
module tb_testfmem_ws;
  import testfmem_pkg::*;

  localparam int unsigned DW    = 36;
  localparam int unsigned AW    = 18;
  localparam int unsigned DL    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int          WA    = 2;
  localparam int          WB    = 0;
`ifdef TESTFMEM_CLEAR_EN
  localparam bit ClearEn = 1'b1;
`else
  localparam bit ClearEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  testfmem_ws_if #(.DATA_W(DW), .ADDR_W(AW)) a_if ();
  testfmem_ws_if #(.DATA_W(DW), .ADDR_W(AW)) b_if ();

  testfmem_ws #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(DL), .WAIT_CYCLES(WA)
  ) dut_a (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (a_if)
  );

  testfmem_ws #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(DL), .WAIT_CYCLES(WB)
  ) dut_b (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (b_if)
  );

  logic [DW-1:0] model_a [DEPTH];
  logic [DW-1:0] model_b [DEPTH];
  int checks = 0;
  int errors = 0;

  function automatic logic [DW-1:0] rand_word();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[DW-1:0];
  endfunction

  task automatic set_bus(input bit sel, input logic rd, input logic wr,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    if (sel) begin
      b_if.i_read = rd; b_if.i_write = wr; b_if.i_address = addr; b_if.i_writedata = wd;
    end else begin
      a_if.i_read = rd; a_if.i_write = wr; a_if.i_address = addr; a_if.i_writedata = wd;
    end
  endtask

  function automatic logic get_wait(input bit sel);
    return sel ? b_if.o_waitrequest : a_if.o_waitrequest;
  endfunction

  function automatic logic [DW-1:0] get_rdata(input bit sel);
    return sel ? b_if.o_readdata : a_if.o_readdata;
  endfunction

  // Present a request from posedge+1 and hold it until accepted (bounded)
  task automatic access(input bit sel, input logic rd, input logic wr,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        output int waits, output logic [DW-1:0] rdata,
                        output bit stall_rd_bad);
    bit done;
    waits = 0; rdata = '0; stall_rd_bad = 1'b0; done = 1'b0;
    set_bus(sel, rd, wr, addr, wd);
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (get_wait(sel) !== 1'b0) begin
        waits++;
        if (get_rdata(sel) !== '0) stall_rd_bad = 1'b1;
      end else begin
        rdata = get_rdata(sel);
        done  = 1'b1;
      end
    end
    @(posedge clk); #1;
    set_bus(sel, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
`ifdef TESTFMEM_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin model_a[i] = '0; model_b[i] = '0; end
    repeat (DEPTH + 1) @(posedge clk);
    #1;
`endif
  endtask

  task automatic test_reset();
    set_bus(1'b0, 1'b1, 1'b0, 18'd5, '0);
    set_bus(1'b1, 1'b1, 1'b0, 18'd5, '0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (a_if.o_waitrequest !== 1'b1) begin
      errors++; $display("FAIL reset_wait_a: got %b want 1", a_if.o_waitrequest);
    end
    checks++;
    if (b_if.o_waitrequest !== ClearEn) begin
      errors++; $display("FAIL reset_wait_b: got %b want %b", b_if.o_waitrequest, ClearEn);
    end
    checks++;
    if (a_if.o_readdata !== '0) begin
      errors++; $display("FAIL reset_rdata_a: got %0h want 0", a_if.o_readdata);
    end
    set_bus(1'b0, 1'b0, 1'b0, '0, '0);
    set_bus(1'b1, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (a_if.o_waitrequest !== ClearEn) begin
      errors++; $display("FAIL idle_wait_a: got %b want %b", a_if.o_waitrequest, ClearEn);
    end
    checks++;
    if (a_if.o_readdata !== '0) begin
      errors++; $display("FAIL idle_rdata_a: got %0h want 0", a_if.o_readdata);
    end
    @(posedge clk); #1;
`ifdef TESTFMEM_CLEAR_EN
    repeat (DEPTH) @(posedge clk);
    #1;
`endif
  endtask

  task automatic test_fill();
    int w; logic [DW-1:0] rd; bit bad; logic [DW-1:0] d;
    for (int i = 0; i < DEPTH; i++) begin
      d = rand_word();
      access(1'b0, 1'b0, 1'b1, AW'(i), d, w, rd, bad);
      model_a[i] = d;
      checks++;
      if (w !== WA || rd !== '0) begin
        errors++; $display("FAIL fill addr %0d: waits %0d rdata %0h want %0d 0", i, w, rd, WA);
      end
    end
  endtask

  task automatic test_write_read();
    int w; logic [DW-1:0] rd; bit bad;
    logic [DW-1:0] v;
    v = 36'o123456701234;
    access(1'b0, 1'b0, 1'b1, 18'd5, v, w, rd, bad);
    model_a[5] = v;
    checks++;
    if (w !== WA) begin errors++; $display("FAIL wr5_waits: got %0d want %0d", w, WA); end
    access(1'b0, 1'b1, 1'b0, 18'd5, '0, w, rd, bad);
    checks++;
    if (w !== WA) begin errors++; $display("FAIL rd5_waits: got %0d want %0d", w, WA); end
    checks++;
    if (rd !== v) begin errors++; $display("FAIL rd5_data: got %0o want %0o", rd, v); end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL rd5_stall_data: nonzero during stall"); end
    @(negedge clk);
    checks++;
    if (a_if.o_readdata !== '0) begin
      errors++; $display("FAIL rd5_after: got %0o want 0", a_if.o_readdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_alias();
    int w; logic [DW-1:0] rd; bit bad;
    access(1'b0, 1'b0, 1'b1, 18'o21, 36'o777, w, rd, bad);
    model_a[1] = 36'o777;
    access(1'b0, 1'b1, 1'b0, 18'd1, '0, w, rd, bad);
    checks++;
    if (rd !== 36'o777 || w !== WA) begin
      errors++; $display("FAIL alias: got %0o waits %0d want 777 waits %0d", rd, w, WA);
    end
  endtask

  task automatic test_abort();
    int w; logic [DW-1:0] rd; bit bad;
    set_bus(1'b0, 1'b0, 1'b1, 18'd3, ~model_a[3]);
    @(posedge clk); #1;
    set_bus(1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    access(1'b0, 1'b1, 1'b0, 18'd3, '0, w, rd, bad);
    checks++;
    if (rd !== model_a[3]) begin
      errors++; $display("FAIL abort_data: got %0h want %0h", rd, model_a[3]);
    end
    checks++;
    if (w !== WA) begin errors++; $display("FAIL abort_rewait: got %0d want %0d", w, WA); end
  endtask

  task automatic test_rw_same();
    int w; logic [DW-1:0] rd; bit bad;
    access(1'b0, 1'b0, 1'b1, 18'd7, 36'o11, w, rd, bad);
    access(1'b0, 1'b1, 1'b1, 18'd7, 36'o22, w, rd, bad);
    model_a[7] = 36'o22;
    checks++;
    if (rd !== 36'o11) begin errors++; $display("FAIL rw_old: got %0o want 11", rd); end
    access(1'b0, 1'b1, 1'b0, 18'd7, '0, w, rd, bad);
    checks++;
    if (rd !== 36'o22) begin errors++; $display("FAIL rw_new: got %0o want 22", rd); end
  endtask

  task automatic test_change_during_stall();
    int w; logic [DW-1:0] rd; bit bad; logic [DW-1:0] d1, d2;
    d1 = ~model_a[9];
    d2 = rand_word();
    set_bus(1'b0, 1'b0, 1'b1, 18'd9, d1);
    @(posedge clk); #1;
    access(1'b0, 1'b0, 1'b1, 18'd10, d2, w, rd, bad);
    model_a[10] = d2;
    checks++;
    if (w !== WA - 1) begin errors++; $display("FAIL chg_waits: got %0d want %0d", w, WA - 1); end
    access(1'b0, 1'b1, 1'b0, 18'd9, '0, w, rd, bad);
    checks++;
    if (rd !== model_a[9]) begin errors++; $display("FAIL chg_old: got %0h want %0h", rd, model_a[9]); end
    access(1'b0, 1'b1, 1'b0, 18'd10, '0, w, rd, bad);
    checks++;
    if (rd !== d2) begin errors++; $display("FAIL chg_new: got %0h want %0h", rd, d2); end
  endtask

  task automatic test_back_to_back();
    int w; logic [DW-1:0] rd; bit bad; logic [DW-1:0] d, exp; logic [AW-1:0] ad;
    logic r, wr;
    for (int i = 0; i < 8; i++) begin
      ad = AW'($urandom); d = rand_word();
      r = i[0]; wr = ~i[0];
      exp = r ? model_a[ad[DL-1:0]] : '0;
      access(1'b0, r, wr, ad, d, w, rd, bad);
      if (wr) model_a[ad[DL-1:0]] = d;
      checks++;
      if (w !== WA || rd !== exp) begin
        errors++; $display("FAIL b2b %0d: waits %0d rdata %0h want %0d %0h", i, w, rd, WA, exp);
      end
    end
  endtask

  task automatic test_random();
    int w; logic [DW-1:0] rd; bit bad; logic [DW-1:0] d, exp; logic [AW-1:0] ad;
    int op;
    for (int i = 0; i < 40; i++) begin
      ad = AW'($urandom); d = rand_word(); op = $urandom_range(0, 3);
      if (op == 3) begin
        set_bus(1'b0, 1'b0, 1'b1, ad, d);
        repeat ($urandom_range(1, WA - 1)) @(posedge clk);
        #1;
        set_bus(1'b0, 1'b0, 1'b0, '0, '0);
      end else begin
        exp = (op != 1) ? model_a[ad[DL-1:0]] : '0;
        access(1'b0, op != 1, op != 0, ad, d, w, rd, bad);
        if (op != 0) model_a[ad[DL-1:0]] = d;
        checks++;
        if (w !== WA || rd !== exp || bad) begin
          errors++;
          $display("FAIL rand %0d op %0d: waits %0d rdata %0h want %0d %0h", i, op, w, rd, WA, exp);
        end
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      access(1'b0, 1'b1, 1'b0, AW'(i), '0, w, rd, bad);
      checks++;
      if (rd !== model_a[i]) begin
        errors++; $display("FAIL rand_final addr %0d: got %0h want %0h", i, rd, model_a[i]);
      end
    end
  endtask

  task automatic test_wait0();
    int w; logic [DW-1:0] rd; bit bad; logic [DW-1:0] d;
    int max_w;
    max_w = 0;
    for (int i = 0; i < DEPTH; i++) begin
      d = rand_word();
      access(1'b1, 1'b0, 1'b1, AW'(i), d, w, rd, bad);
      model_b[i] = d;
      if (w > max_w) max_w = w;
    end
    for (int i = 0; i < DEPTH; i++) begin
      access(1'b1, 1'b1, 1'b0, AW'(i), '0, w, rd, bad);
      if (w > max_w) max_w = w;
      checks++;
      if (rd !== model_b[i]) begin
        errors++; $display("FAIL w0_read addr %0d: got %0h want %0h", i, rd, model_b[i]);
      end
    end
    checks++;
    if (max_w !== WB) begin errors++; $display("FAIL w0_waits: got %0d want %0d", max_w, WB); end
  endtask

  task automatic test_reset_mid_access();
    int w; logic [DW-1:0] rd; bit bad;
    set_bus(1'b0, 1'b0, 1'b1, 18'd12, ~model_a[12]);
    @(posedge clk); #1;
    rst_n = 1'b0;
    set_bus(1'b1, 1'b0, 1'b1, 18'd4, ~model_b[4]);
    #1;
    checks++;
    if (a_if.o_waitrequest !== 1'b1) begin
      errors++; $display("FAIL rstmid_wait: got %b want 1", a_if.o_waitrequest);
    end
    repeat (2) @(posedge clk);
    #1;
    set_bus(1'b0, 1'b0, 1'b0, '0, '0);
    set_bus(1'b1, 1'b0, 1'b0, '0, '0);
    release_reset();
    access(1'b0, 1'b1, 1'b0, 18'd12, '0, w, rd, bad);
    checks++;
    if (rd !== model_a[12] || w !== WA) begin
      errors++; $display("FAIL rstmid_a: got %0h waits %0d want %0h %0d", rd, w, model_a[12], WA);
    end
    access(1'b1, 1'b1, 1'b0, 18'd4, '0, w, rd, bad);
    checks++;
    if (rd !== model_b[4]) begin
      errors++; $display("FAIL rstmid_b: got %0h want %0h", rd, model_b[4]);
    end
  endtask

`ifdef TESTFMEM_CLEAR_EN
  task automatic test_clear();
    int w; logic [DW-1:0] rd; bit bad;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    access(1'b0, 1'b1, 1'b0, 18'd5, '0, w, rd, bad);
    for (int i = 0; i < DEPTH; i++) begin model_a[i] = '0; model_b[i] = '0; end
    checks++;
    if (w !== DEPTH + WA) begin
      errors++; $display("FAIL clear_waits: got %0d want %0d", w, DEPTH + WA);
    end
    for (int i = 0; i < DEPTH; i++) begin
      access(1'b0, 1'b1, 1'b0, AW'(i), '0, w, rd, bad);
      checks++;
      if (rd !== '0) begin errors++; $display("FAIL clear_word %0d: got %0h want 0", i, rd); end
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    set_bus(1'b0, 1'b0, 1'b0, '0, '0);
    set_bus(1'b1, 1'b0, 1'b0, '0, '0);
    test_reset();
    test_fill();
    test_write_read();
    test_alias();
    test_abort();
    test_rw_same();
    test_change_during_stall();
    test_back_to_back();
    test_random();
    test_wait0();
    test_reset_mid_access();
`ifdef TESTFMEM_CLEAR_EN
    test_clear();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
